tx_flt_seq: RTL
===============

# tx_flt_seq

Sequencer and clock-enable generator for the practical SRRC transmit filter. It derives `sam_clk_en` and `sym_clk_en` from the system clock and accepts symbols from the upstream mapper over a valid/ready handshake. It zero-stuffs the symbols into the filter input at SAM_PER_SYM samples per symbol. It also runs the start / stream / flush lifecycle, so the filter is fully drained of data before the transmitter goes idle.

## Interface
- `CLK_PER_SAM`, default 4: clk cycles per sample enable; must be ≥1.
- `SAM_PER_SYM`, default 4: samples per symbol; must be ≥2.
- `FLUSH_SAMS`, default 132: zero samples pushed in FLUSH. Derivation: 115 taps + 1 adder register + 1 output register + 14 delay-chain samples + 1 margin.
- `LAT_SAMS`, default 16: sample enables from first symbol injection to `flt_out_valid` rising.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low.
- `start` in 1: pulse that requests streaming.
- `stop` in 1: pulse that requests end of stream.
- `sym_in` in 18: signed symbol, one of `SYMBOL_P2/P1/N1/N2` (defines.vh).
- `sym_valid` in 1: `sym_in` is valid.
- `sym_ready` out 1: the sequencer accepts a symbol this cycle.
- `sam_clk_en` out 1: sample enable to the filter and delay chain.
- `sym_clk_en` out 1: symbol enable; always coincident with a `sam_clk_en`.
- `flt_in` out 18: signed input to the filter.
- `flt_out_valid` out 1: the filter output carries the live stream.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse when FLUSH completes.
- `underrun` out 1: one-cycle pulse when a symbol slot was missed.
- `underrun_cnt` out 16: saturating count of missed symbol slots.

## Operation
- **Counters.**
  - `clk_cnt` counts 0..CLK_PER_SAM-1 and wraps.
  - `sam_clk_en` is high when `clk_cnt`==CLK_PER_SAM-1.
  - `sam_cnt` counts 0..SAM_PER_SYM-1 and advances on each `sam_clk_en`.
  - `sym_clk_en` = `sam_clk_en` && `sam_cnt`==0.
  - Both counters free-run in every state, so the filter always clocks.
- **States:** IDLE, RUN, FLUSH.
  - `start` and `stop` are latched into pending flags. A flag clears when it is acted on.
  - IDLE→RUN on a `sym_clk_en` cycle while start is pending.
  - RUN→FLUSH on a `sym_clk_en` cycle while stop is pending. That slot is treated as a non-RUN slot.
  - FLUSH→IDLE on the `sam_clk_en` that completes FLUSH_SAMS samples counted in FLUSH. `done` pulses on that cycle.
  - `start` arriving in FLUSH stays pending; the block re-enters RUN at the first symbol slot after IDLE.
  - `stop` in IDLE is discarded.
  - Simultaneous `start` and `stop` in IDLE: start wins and stop stays pending. The result is one symbol slot of RUN, then FLUSH.
- **Handshake.**
  - `sym_ready` = (state==RUN) && `sym_clk_en` && !stop-pending.
  - A transfer occurs when `sym_valid` && `sym_ready`.
  - `sym_valid` outside a ready cycle is ignored; no data is consumed.
- **Filter input.** `flt_in` updates only on `sam_clk_en` edges:
  - `sym_in` on a transfer;
  - otherwise 0.
  - This yields exactly one symbol sample followed by SAM_PER_SYM-1 zero samples.
- **Underrun.** A ready cycle without `sym_valid`:
  - injects 0;
  - pulses `underrun`;
  - increments `underrun_cnt`, which saturates at 16'hFFFF.
  - The state is unchanged.
- **`flt_out_valid`.**
  - Sets LAT_SAMS sample enables after the first transfer following RUN entry.
  - Clears on the `done` cycle.

## Timing
- **Reset.** `reset`=0 sampled at a clk edge forces:
  - all outputs to 0;
  - counters to 0, state to IDLE, pending flags cleared.
  - This applies equally mid-RUN or mid-FLUSH; the in-progress symbol is dropped.
- **First enables.** The first `sam_clk_en` and `sym_clk_en` occur CLK_PER_SAM-1 cycles after the first cycle with `reset`=1. With CLK_PER_SAM=1, `sam_clk_en` is constantly 1.
- **Injection latency.** A symbol transferred at edge E appears on `flt_in` after E. The filter captures it at the next `sam_clk_en`, CLK_PER_SAM cycles later.
- **Registered outputs.** `underrun`, `done` and the state transitions are registered. Each is visible the cycle after its triggering `sym_clk_en` or `sam_clk_en`.

## Configuration
- **`TX_SEQ_IMPULSE_EN` defined:**
  - adds input `impulse` (1 bit, pulse, latched as pending);
  - in IDLE, at the next symbol slot, injects a single `SYMBOL_P2` onto `flt_in`, ignoring the handshake;
  - then enters FLUSH directly;
  - `flt_out_valid` behaves as for a one-symbol stream;
  - `start` has priority over `impulse` when both are pending.
- **`TX_SEQ_IMPULSE_EN` undefined:** no `impulse` port and no impulse logic.

## Test plan
All scenarios use CLK_PER_SAM=4 and SAM_PER_SYM=4.
- **Reset release.** Hold `reset`=0 for 5 cycles, then release → `sam_clk_en` pulses at cycles 3, 7, 11… after release; `sym_clk_en` pulses at cycles 3, 19, 35…; all other outputs are 0.
- **Streaming.** Pulse `start` and stream `SYMBOL_P1`, `SYMBOL_N2`, `SYMBOL_P2` with `sym_valid`=1 → `flt_in` sample sequence is P1,0,0,0,N2,0,0,0,P2,0,0,0; `sym_ready` is high for exactly 1 cycle per 16.
- **Underrun.** In RUN, drop `sym_valid` for 2 symbol slots → 2 `underrun` pulses; `underrun_cnt`=2; `flt_in` is 0 for 8 samples; state stays RUN.
- **Stop and flush.** Pulse `stop` mid-symbol → `sym_ready` stays low from the next slot; FLUSH lasts 132 `sam_clk_en`; one `done` pulse; `busy` and `flt_out_valid` are 0 the next cycle.
- **Reset during FLUSH.** Assert `reset`=0 for 1 cycle mid-FLUSH → state IDLE; no `done` pulse; `underrun_cnt`=0; `flt_in`=0.
- **Impulse** (`TX_SEQ_IMPULSE_EN`). Pulse `impulse` in IDLE → a single P2 sample, then 132 zeros, then `done`; `underrun` never pulses.

Source files
------------

// File: rtl/tx_flt_seq.sv
// Sequencer and clock-enable generator for the SRRC transmit filter: sample/symbol enables,
// zero-stuffed symbol injection and the start/run/flush lifecycle. Option: TX_SEQ_IMPULSE_EN.
module tx_flt_seq #(
  parameter int unsigned ClkPerSam = 4,
  parameter int unsigned SamPerSym = 4,
  parameter int unsigned FlushSams = 132,
  parameter int unsigned LatSams   = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               stop_i,
`ifdef TX_SEQ_IMPULSE_EN
  input  logic               impulse_i,
`endif
  input  logic signed [17:0] sym_i,
  input  logic               sym_valid_i,
  output logic               sym_ready_o,
  output logic               sam_clk_en_o,
  output logic               sym_clk_en_o,
  output logic signed [17:0] flt_in_o,
  output logic               flt_out_valid_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               underrun_o,
  output logic [15:0]        underrun_cnt_o
);

  localparam int unsigned ClkW   = (ClkPerSam > 1) ? $clog2(ClkPerSam) : 1;
  localparam int unsigned SamW   = $clog2(SamPerSym);
  localparam int unsigned FlushW = $clog2(FlushSams + 1);
  localparam int unsigned LatW   = $clog2(LatSams + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e             state_q;
  logic [ClkW-1:0]    clk_cnt_q;
  logic [SamW-1:0]    sam_cnt_q;
  logic [FlushW-1:0]  flush_cnt_q;
  logic [LatW-1:0]    lat_cnt_q;
  logic               start_pend_q, stop_pend_q;
  logic               arm_q, lat_run_q, out_valid_q, done_q, underrun_q;
  logic [15:0]        underrun_cnt_q;
  logic signed [17:0] flt_in_q;

  logic               sam_en, sym_en, sym_ready, xfer, miss;
  logic               go_run, go_flush, go_imp, flush_last, lat_start;
  logic signed [17:0] inject_val;

`ifdef TX_SEQ_IMPULSE_EN
  localparam logic signed [17:0] SymbolP2 = 18'sd98304;
  logic imp_pend_q;
`endif

  always_comb begin
    sam_en     = (clk_cnt_q == ClkW'(ClkPerSam - 1));
    sym_en     = sam_en && (sam_cnt_q == '0);
    // A slot that sees a pending stop belongs to FLUSH, so it is never offered upstream.
    sym_ready  = (state_q == StRun) && sym_en && !stop_pend_q;
    xfer       = sym_ready && sym_valid_i;
    miss       = sym_ready && !sym_valid_i;
    go_run     = (state_q == StIdle) && sym_en && start_pend_q;
    go_flush   = (state_q == StRun) && sym_en && stop_pend_q;
    flush_last = (state_q == StFlush) && sam_en && (flush_cnt_q == FlushW'(FlushSams - 1));
`ifdef TX_SEQ_IMPULSE_EN
    go_imp     = (state_q == StIdle) && sym_en && imp_pend_q && !start_pend_q;
    inject_val = xfer ? sym_i : (go_imp ? SymbolP2 : '0);
`else
    go_imp     = 1'b0;
    inject_val = xfer ? sym_i : '0;
`endif
    lat_start  = (xfer && arm_q) || go_imp;
  end

  // Enables free-run in every state so the filter pipeline keeps clocking.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      clk_cnt_q <= '0;
      sam_cnt_q <= '0;
    end else begin
      clk_cnt_q <= sam_en ? '0 : clk_cnt_q + 1'b1;
      if (sam_en) begin
        sam_cnt_q <= (sam_cnt_q == SamW'(SamPerSym - 1)) ? '0 : sam_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      flush_cnt_q    <= '0;
      lat_cnt_q      <= '0;
      start_pend_q   <= 1'b0;
      stop_pend_q    <= 1'b0;
      arm_q          <= 1'b0;
      lat_run_q      <= 1'b0;
      out_valid_q    <= 1'b0;
      done_q         <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
      flt_in_q       <= '0;
`ifdef TX_SEQ_IMPULSE_EN
      imp_pend_q     <= 1'b0;
`endif
    end else begin
      start_pend_q <= (start_pend_q & ~go_run) | start_i;
      // Outside RUN a stop only survives when it rides along with a pending start.
      if (state_q == StRun) begin
        stop_pend_q <= (stop_pend_q & ~go_flush) | stop_i;
      end else begin
        stop_pend_q <= (stop_pend_q | stop_i) & (start_pend_q | start_i);
      end
`ifdef TX_SEQ_IMPULSE_EN
      imp_pend_q <= (imp_pend_q & ~go_imp) | impulse_i;
`endif
      done_q     <= flush_last;
      underrun_q <= miss;
      if (miss && (underrun_cnt_q != 16'hFFFF)) begin
        underrun_cnt_q <= underrun_cnt_q + 16'd1;
      end
      if (sam_en) begin
        flt_in_q <= inject_val;
      end

      unique case (state_q)
        StIdle: begin
          if (go_run) begin
            state_q <= StRun;
          end else if (go_imp) begin
            state_q <= StFlush;
          end
        end
        StRun: begin
          if (go_flush) begin
            state_q <= StFlush;
          end
        end
        StFlush: begin
          if (sam_en) begin
            if (flush_last) begin
              state_q     <= StIdle;
              flush_cnt_q <= '0;
            end else begin
              flush_cnt_q <= flush_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      // Output-valid latency is timed from the first injection after entering RUN.
      if (go_run) begin
        arm_q <= 1'b1;
      end
      if (lat_start) begin
        arm_q     <= 1'b0;
        lat_run_q <= 1'b1;
        lat_cnt_q <= '0;
      end else if (lat_run_q && sam_en) begin
        if (lat_cnt_q == LatW'(LatSams - 1)) begin
          lat_run_q   <= 1'b0;
          out_valid_q <= 1'b1;
        end else begin
          lat_cnt_q <= lat_cnt_q + 1'b1;
        end
      end
      if (flush_last) begin
        out_valid_q <= 1'b0;
        lat_run_q   <= 1'b0;
        arm_q       <= 1'b0;
      end
    end
  end

  assign sym_ready_o     = sym_ready;
  assign sam_clk_en_o    = sam_en;
  assign sym_clk_en_o    = sym_en;
  assign flt_in_o        = flt_in_q;
  assign flt_out_valid_o = out_valid_q;
  assign busy_o          = (state_q != StIdle);
  assign done_o          = done_q;
  assign underrun_o      = underrun_q;
  assign underrun_cnt_o  = underrun_cnt_q;

endmodule
